// File: rtl/deck_shuffler.sv
// 52-card deck store: a one-swap-per-clock shuffle sweep driven by an external
// swap-address generator, followed by one-card-at-a-time dealing on request.
module deck_shuffler #(
  parameter int DECK_SIZE = 52,
  parameter int CARD_W    = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Shuffle_Start,
  input  logic [CARD_W-1:0] Addr_j,
  input  logic              Deal_Req,
  output logic [CARD_W-1:0] Addr_i,
  output logic [CARD_W-1:0] Card,
  output logic              Card_Valid,
  output logic              Busy,
  output logic              Shuffle_Done,
  output logic              Deck_Empty,
  output logic [CARD_W-1:0] Cards_Left,
  output logic [1:0]        Dbg_State
);

  // Shuffle_Start and Deal_Req are single-cycle requests sampled on the rising
  // edge; Card_Valid is a one-cycle strobe with no backpressure from the consumer.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHUFFLE = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;

  localparam logic [CARD_W-1:0] LAST_IDX = CARD_W'(DECK_SIZE - 1);
  localparam logic [CARD_W-1:0] FULL_CNT = CARD_W'(DECK_SIZE);

  logic [1:0]        r_state;
  logic [CARD_W-1:0] r_deck [DECK_SIZE];
  logic [CARD_W-1:0] r_addr_i;
  logic [CARD_W-1:0] r_ptr;
  logic [CARD_W-1:0] r_card;
  logic              r_card_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_empty;
  logic [CARD_W-1:0] r_left;

  logic [CARD_W-1:0] w_j;
  logic [CARD_W-1:0] w_card_i;
  logic [CARD_W-1:0] w_card_j;
  logic [CARD_W-1:0] w_card_p;

  // Out-of-range partners collapse onto the source so the deck stays a permutation.
  assign w_j = (Addr_j >= FULL_CNT) ? r_addr_i : Addr_j;

  always_comb begin
    w_card_i = '0;
    w_card_j = '0;
    w_card_p = '0;
    for (int k = 0; k < DECK_SIZE; k++) begin
      if (CARD_W'(k) == r_addr_i) w_card_i = r_deck[k];
      if (CARD_W'(k) == w_j)      w_card_j = r_deck[k];
      if (CARD_W'(k) == r_ptr)    w_card_p = r_deck[k];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < DECK_SIZE; k++) r_deck[k] <= CARD_W'(k);
      r_state      <= S_IDLE;
      r_addr_i     <= '0;
      r_ptr        <= '0;
      r_card       <= '0;
      r_card_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_empty      <= 1'b0;
      r_left       <= FULL_CNT;
    end else begin
      r_card_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Shuffle_Start) begin
            r_state  <= S_SHUFFLE;
            r_busy   <= 1'b1;
            r_addr_i <= '0;
          end
        end
        S_SHUFFLE: begin
          // When w_j equals the source both writes carry the same value.
          for (int k = 0; k < DECK_SIZE; k++) begin
            if (CARD_W'(k) == r_addr_i)  r_deck[k] <= w_card_j;
            else if (CARD_W'(k) == w_j)  r_deck[k] <= w_card_i;
          end
          if (r_addr_i == LAST_IDX) begin
            r_state  <= S_READY;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_addr_i <= '0;
            r_ptr    <= '0;
            r_left   <= FULL_CNT;
            r_empty  <= 1'b0;
          end else begin
            r_addr_i <= r_addr_i + 1'b1;
          end
        end
        S_READY: begin
          if (Shuffle_Start) begin
            r_state  <= S_SHUFFLE;
            r_busy   <= 1'b1;
            r_addr_i <= '0;
          end else if (Deal_Req && !r_empty) begin
            r_card       <= w_card_p;
            r_card_valid <= 1'b1;
            r_ptr        <= r_ptr + 1'b1;
            r_left       <= r_left - 1'b1;
            r_empty      <= (r_left == CARD_W'(1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Addr_i       = r_addr_i;
  assign Card         = r_card;
  assign Card_Valid   = r_card_valid;
  assign Busy         = r_busy;
  assign Shuffle_Done = r_done;
  assign Deck_Empty   = r_empty;
  assign Cards_Left   = r_left;
  assign Dbg_State    = r_state;

endmodule

// File: doc/deck_shuffler.md
Name: deck_shuffler

Overview:
Owns the 52-card deck storage and consumes the pseudo-random swap address produced by the next-address generator.
- During a shuffle pass it walks source index Addr_i from 0 to 51 and swaps deck[Addr_i] with deck[Addr_j], one swap per clock (Fisher–Yates-style sweep).
- After the pass it serves cards to the game FSM one at a time on request.
- It sits between the free-running counter / next-address generator and the player/dealer hand logic.

Parameters:
DECK_SIZE, 52, number of cards and deck entries (card codes 0..DECK_SIZE-1)
CARD_W, 6, width of card codes, deck indices and the remaining-card count

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Shuffle_Start  input  1  single-cycle request to begin a shuffle pass
Addr_j  input  CARD_W  swap partner index from the next-address generator, combinational function of Addr_i
Deal_Req  input  1  single-cycle request for the next card
Addr_i  output  CARD_W  current source index driven to the next-address generator
Card  output  CARD_W  dealt card code, valid only when Card_Valid=1
Card_Valid  output  1  one-cycle strobe accompanying Card
Busy  output  1  high while the shuffle pass is running
Shuffle_Done  output  1  one-cycle pulse when the pass completes
Deck_Empty  output  1  high when all DECK_SIZE cards have been dealt
Cards_Left  output  CARD_W  number of undealt cards

Behaviour:
- Reset (async, any state):
  - deck[k]=k for all k; state IDLE.
  - Addr_i=0, Card=0, Card_Valid=0, Busy=0, Shuffle_Done=0.
  - Deck_Empty=0, Cards_Left=DECK_SIZE, deal pointer=0.
- States: IDLE, SHUFFLE, READY.
- IDLE:
  - Deal_Req is ignored.
  - Shuffle_Start=1 -> SHUFFLE next cycle with Addr_i=0 and Busy=1.
- SHUFFLE:
  - Each cycle, deck[Addr_i] and deck[Addr_j] are exchanged in the same edge.
  - Addr_j is sampled in the same cycle Addr_i is presented; there is no pipeline stage.
  - Addr_j==Addr_i -> no change.
  - Addr_j>=DECK_SIZE -> treated as Addr_i (no swap), so the deck always stays a permutation.
  - Addr_i increments by 1 per cycle.
  - On the cycle Addr_i==DECK_SIZE-1 the final swap occurs. Next edge: state READY, Busy=0, Shuffle_Done=1 for exactly one cycle, Addr_i=0, deal pointer=0, Cards_Left=DECK_SIZE, Deck_Empty=0.
  - A pass takes exactly DECK_SIZE cycles with Busy high.
  - Shuffle_Start and Deal_Req are ignored during SHUFFLE.
- The pass permutes the current deck contents; it does not reinitialise to identity. Repeated shuffles compound.
- READY:
  - Deal_Req=1 with Deck_Empty=0 -> on the next edge Card=deck[pointer] and Card_Valid=1 for one cycle; pointer and Cards_Left update on the same edge.
  - Latency is 1 cycle. Back-to-back Deal_Req on consecutive cycles yields consecutive cards.
  - When Cards_Left reaches 0, Deck_Empty=1. Deal_Req while Deck_Empty=1 -> no strobe and no state change.
  - Shuffle_Start=1 -> SHUFFLE, resetting the deal pointer at pass end. If Shuffle_Start and Deal_Req arrive in the same cycle, Shuffle_Start wins and no card is dealt.
- Card holds its last value when Card_Valid=0.
- Card code meaning is defined downstream (rank = code mod 13); this block treats codes as opaque.

Test Plan:
1. Reset, then deal 52 times from READY after a pass with Addr_j tied to Addr_i -> cards 0,1,...,51 in order. Deck_Empty=1 after the 52nd; a 53rd Deal_Req gives no Card_Valid.
2. Pass with Addr_j forced to 0 -> Busy high exactly 52 cycles, one Shuffle_Done pulse. Deal sequence is 51,0,1,...,50.
3. Pass with Addr_j=63 for all i -> deck unchanged (out-of-range guard); deal yields 0..51.
4. Pulse Shuffle_Start and Deal_Req during SHUFFLE at i=10 -> both ignored; pass ends at the expected cycle and Card_Valid never asserts.
5. Assert Reset at i=30 mid-shuffle -> outputs return to reset values immediately; deck reads back as identity after an Addr_j=Addr_i pass.
6. Deal 5 cards, then Shuffle_Start with Deal_Req in the same cycle -> no card dealt, pass runs; after it Cards_Left=52 and the 52 dealt codes form a permutation of 0..51.
